// File: rtl/const_decoder.sv
// Compensation-word decoder: accepts one CONST_W-bit word, checks its header,
// scans the body one position per cycle and reports the accuracy level or an error.
module const_decoder #(
    parameter int ACC_MAX = 11
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [2*ACC_MAX+1:0]                 const_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(ACC_MAX+1)-1:0]         acc_out,
    output logic                                 err_out
);

    localparam int CONST_W = 2*ACC_MAX + 2;
    localparam int AW      = $clog2(ACC_MAX + 1);
    localparam int PW      = $clog2(CONST_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CONST_W-1:0]   shift_q, shift_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic                 nz_q, nz_d;        // header 10: a nonzero level is expected
    logic                 found_q, found_d;
    logic                 scan_err_q, scan_err_d;
    logic [AW-1:0]        level_q, level_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            pos_q      <= '0;
            nz_q       <= 1'b0;
            found_q    <= 1'b0;
            scan_err_q <= 1'b0;
            level_q    <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            pos_q      <= pos_d;
            nz_q       <= nz_d;
            found_q    <= found_d;
            scan_err_q <= scan_err_d;
            level_q    <= level_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        logic          bit_now;
        logic          f_now;
        logic          e_now;
        logic          fin_err;
        logic [AW-1:0] lv_now;
        logic [PW-1:0] half;

        state_d    = state_q;
        shift_d    = shift_q;
        pos_d      = pos_q;
        nz_d       = nz_q;
        found_d    = found_q;
        scan_err_d = scan_err_q;
        level_d    = level_q;
        acc_d      = acc_q;
        err_d      = err_q;
        bit_now    = shift_q[CONST_W-1];
        f_now      = found_q;
        e_now      = scan_err_q;
        lv_now     = level_q;
        fin_err    = 1'b0;
        half       = (pos_q - PW'(2)) >> 1;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d    = const_in;
                    pos_d      = PW'(3);
                    found_d    = 1'b0;
                    scan_err_d = 1'b0;
                    level_d    = '0;
                    state_d    = HDR;
                end
            end
            HDR: begin
                shift_d = shift_q << 2;
                case (shift_q[CONST_W-1 -: 2])
                    2'b11: begin
                        nz_d    = 1'b0;
                        state_d = SCAN;
                    end
                    2'b10: begin
                        nz_d    = 1'b1;
                        state_d = SCAN;
                    end
                    default: begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        state_d = DONE;
                    end
                endcase
            end
            SCAN: begin
                shift_d = shift_q << 1;
                pos_d   = pos_q + PW'(1);
                if (bit_now) begin
                    if (found_q || pos_q[0]) begin
                        e_now = 1'b1;
                    end else begin
                        lv_now = AW'(half);
                    end
                    f_now = 1'b1;
                end
                found_d    = f_now;
                scan_err_d = e_now;
                level_d    = lv_now;
                if (pos_q == PW'(CONST_W)) begin
                    fin_err = e_now | (nz_q & ~f_now) | (~nz_q & f_now);
                    err_d   = fin_err;
                    acc_d   = (fin_err || !nz_q) ? '0 : lv_now;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_const_decoder.sv
// Directed bench for const_decoder at ACC_MAX=11 (24-bit words, 4-bit level).
module tb_const_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] const_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  acc_out;
    logic        err_out;

    int vectors;
    int miscompares;

    const_decoder #(.ACC_MAX(11)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .const_in  (const_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .err_out   (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a word until accepted, then counts edges (accept edge = 1)
    // until out_valid is seen; lat = -1 if it never appears.
    task automatic send_word(input logic [23:0] word, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        const_in = word;
        @(posedge clk); #1;
        in_valid = 1'b0;
        const_in = 24'(~word);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({in_ready, out_valid, acc_out, err_out} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_during: in_ready/out_valid/acc/err = %b/%b/%0d/%b required 1/0/0/0",
                     in_ready, out_valid, acc_out, err_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors++;
        if ({in_ready, out_valid, acc_out, err_out} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_after: in_ready/out_valid/acc/err = %b/%b/%0d/%b required 1/0/0/0",
                     in_ready, out_valid, acc_out, err_out);
        end
        $display("reset: released, in_ready=%b", in_ready);
    endtask

    task automatic test_decode();
        logic [23:0] words [10];
        int          lats  [10];
        int          accs  [10];
        logic        errs  [10];
        int          lat;
        words = '{24'h801000, 24'hC00000, 24'h800001, 24'h900000, 24'h400000,
                  24'h000000, 24'h841000, 24'h820000, 24'h800000, 24'hC01000};
        lats  = '{24, 24, 24, 24, 2, 2, 24, 24, 24, 24};
        accs  = '{5, 0, 11, 1, 0, 0, 0, 0, 0, 0};
        errs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int v = 0; v < 10; v++) begin
            send_word(words[v], lat);
            vectors++;
            if (lat !== lats[v]) begin
                miscompares++;
                $display("FAIL latency %h: got T+%0d required T+%0d", words[v], lat, lats[v]);
            end
            vectors++;
            if (acc_out !== 4'(accs[v])) begin
                miscompares++;
                $display("FAIL acc %h: got %0d required %0d", words[v], acc_out, accs[v]);
            end
            vectors++;
            if (err_out !== errs[v]) begin
                miscompares++;
                $display("FAIL err %h: got %b required %b", words[v], err_out, errs[v]);
            end
            $display("decode %h: lat=T+%0d acc=%0d err=%b", words[v], lat, acc_out, err_out);
            release_out();
            vectors++;
            if ({in_ready, out_valid, acc_out, err_out} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL idle_after %h: in_ready/out_valid/acc/err = %b/%b/%0d/%b required 1/0/0/0",
                         words[v], in_ready, out_valid, acc_out, err_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        send_word(24'h900000, lat);
        vectors++;
        if (lat !== 24) begin
            miscompares++;
            $display("FAIL bp_latency: got T+%0d required T+24", lat);
        end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({out_valid, acc_out, err_out, in_ready} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: out_valid/acc/err/in_ready = %b/%0d/%b/%b required 1/1/0/0",
                         c, out_valid, acc_out, err_out, in_ready);
            end
            @(posedge clk); #1;
        end
        release_out();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: in_ready=%b required 1", in_ready);
        end
        $display("back_to_back: first word held 5 cycles, released");
        send_word(24'h800400, lat);
        vectors++;
        if ({lat == 24, acc_out, err_out} !== {1'b1, 4'd6, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_second: lat=T+%0d acc=%0d err=%b required T+24/6/0", lat, acc_out, err_out);
        end
        $display("back_to_back: second word 800400 lat=T+%0d acc=%0d err=%b", lat, acc_out, err_out);
        release_out();
    endtask

    task automatic test_mid_reset();
        int lat;
        in_valid = 1'b1;
        const_in = 24'h800001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, acc_out, err_out} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_async: in_ready/out_valid/acc/err = %b/%b/%0d/%b required 1/0/0/0",
                     in_ready, out_valid, acc_out, err_out);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_hold: out_valid=%b required 0", out_valid);
            end
        end
        rst_n = 1'b1;
        send_word(24'h801000, lat);
        vectors++;
        if ({lat == 24, acc_out, err_out} !== {1'b1, 4'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_new: lat=T+%0d acc=%0d err=%b required T+24/5/0", lat, acc_out, err_out);
        end
        $display("mid_reset: new word 801000 lat=T+%0d acc=%0d err=%b", lat, acc_out, err_out);
        release_out();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        const_in    = '0;
        out_ready   = 1'b0;
        #12;
        test_reset();
        test_decode();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/const_decoder.md
CONST_DECODER -- requirements
Module: const_decoder

Interface
REQ-001 SHALL have parameter ACC_MAX, default 11, the highest accuracy level encodable; legal range 1..15.
REQ-002 SHALL define localparam CONST_W = 2*ACC_MAX+2 (compensation-word width) and localparam AW = clog2(ACC_MAX+1) (level width).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, const_in holds a word to decode.
REQ-006 SHALL have port in_ready, output, 1, block can accept a word.
REQ-007 SHALL have port const_in, input, CONST_W, compensation word; position i (1..CONST_W) maps to bit CONST_W-i.
REQ-008 SHALL have port out_valid, output, 1, the decode result is presented.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port acc_out, output, AW, the decoded accuracy level.
REQ-011 SHALL have port err_out, output, 1, the word was malformed.

Function
REQ-012 SHALL implement FSM states IDLE, HDR, SCAN, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; the accept cycle T is the cycle with in_valid=1 and in_ready=1.
REQ-014 On accept, SHALL latch const_in into a shift register and move to HDR; const_in is ignored outside the accept cycle.
REQ-015 In HDR, SHALL evaluate positions 1..2 (the header): 2'b11 means level 0 is expected; 2'b10 means a nonzero level is expected; 2'b00 or 2'b01 sets the error bit and goes to DONE (out_valid at T+2).
REQ-016 For header 11 or 10, SHALL enter SCAN and examine one position per cycle, positions 3..CONST_W in order, taking exactly CONST_W-2 cycles.
REQ-017 No early exit SHALL occur; out_valid SHALL assert at T+CONST_W for every legal-header word.
REQ-018 Scan rule: a 1 at odd position i SHALL set the error bit.
REQ-019 Scan rule: a 1 at even position i SHALL record level (i-2)/2.
REQ-020 Scan rule: a second 1 at any position SHALL set the error bit.
REQ-021 At the end of the scan, header 10 with no 1 found, or header 11 with any 1 found, SHALL set the error bit.
REQ-022 At the end of the scan, a valid header-10 word SHALL yield the recorded level, and a valid header-11 word SHALL yield level 0.
REQ-023 In DONE, SHALL drive out_valid=1 and hold acc_out and err_out constant until out_ready=1.
REQ-024 In DONE with out_ready=1, SHALL return to IDLE on the next edge, so in_ready=1 in the following cycle; back-to-back throughput is one word per CONST_W+1 cycles minimum.
REQ-025 When err_out=1, acc_out SHALL be 0.
REQ-026 acc_out and err_out SHALL be registered outputs and are don't-care-free: both are 0 whenever out_valid=0.
REQ-027 Level arithmetic SHALL be AW bits wide with no overflow; the maximum is ACC_MAX at position CONST_W.

Reset
REQ-028 While rst_n=0, SHALL immediately force state to IDLE and drive out_valid=0, acc_out=0, err_out=0, and clear the shift register and scan counters; in_ready=1 after reset.
REQ-029 Reset asserted mid-SCAN or in DONE SHALL abandon the word with no output produced.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (ACC_MAX=11, CONST_W=24)
REQ-031 Bench SHALL cover: header 10 with the single 1 at position 12 (bit 12) -> acc_out=5, err_out=0, out_valid at T+24.
REQ-032 Bench SHALL cover: 24'hC00000 (header 11, rest 0) -> acc_out=0, err_out=0 at T+24; 24'h800001 -> acc_out=11, err_out=0.
REQ-033 Bench SHALL cover: header 01 (24'h400000) -> err_out=1, acc_out=0, out_valid at T+2.
REQ-034 Bench SHALL cover: header 10 with 1s at positions 6 and 12, a 1 at odd position 7, and 24'h800000 -> each gives err_out=1, acc_out=0.
REQ-035 Bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid, acc_out and err_out stable and in_ready=0; release -> in_ready=1 on the next cycle, and a back-to-back second word decodes correctly.
REQ-036 Bench SHALL cover: rst_n pulsed low at T+10 -> outputs 0 within the same cycle, no out_valid, and a new word accepted after release decodes correctly.
